// File: rtl/tx_scheduler_pkg.sv
// Shared definitions for the Transmitter scheduler: requester count and FSM encoding.
package tx_scheduler_pkg;

  localparam int NUM_REQ = 2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_READ      = 3'd1,
    ST_CAPTURE   = 3'd2,
    ST_START     = 3'd3,
    ST_WAIT_ACK  = 3'd4,
    ST_WAIT_DONE = 3'd5
  } state_t;

endpackage

// File: rtl/tx_scheduler_if.sv
// FIFO-side and Transmitter-side signals of the scheduler, bundled for the top level.
interface tx_scheduler_if #(
  parameter int WORD_SIZE   = 4,
  parameter int COUNT_WIDTH = 8
);

  logic [tx_scheduler_pkg::NUM_REQ-1:0]           q_empty;
  logic [tx_scheduler_pkg::NUM_REQ-1:0]           q_full;
  logic [tx_scheduler_pkg::NUM_REQ*WORD_SIZE-1:0] q_data;
  logic [tx_scheduler_pkg::NUM_REQ-1:0]           q_read;
  logic [WORD_SIZE-1:0]                           tx_data;
  logic                                           tx_start;
  logic                                           tx_busy;
  logic [tx_scheduler_pkg::NUM_REQ-1:0]           grant;
  logic                                           error;
  logic [COUNT_WIDTH-1:0]                         sent_count;

  // The scheduler is the master: it pops the FIFOs and drives the Transmitter.
  modport master (
    input  q_empty, q_full, q_data, tx_busy,
    output q_read, tx_data, tx_start, grant, error, sent_count
  );

  modport slave (
    output q_empty, q_full, q_data, tx_busy,
    input  q_read, tx_data, tx_start, grant, error, sent_count
  );

endinterface

// File: rtl/tx_scheduler_rr_arbiter.sv
// Picks one non-empty requester: a lone full queue wins, otherwise round-robin from rr_ptr.
module tx_scheduler_rr_arbiter
  import tx_scheduler_pkg::*;
(
  input  logic [NUM_REQ-1:0] q_empty,
  input  logic [NUM_REQ-1:0] q_full,
  input  logic               rr_ptr,
  output logic [NUM_REQ-1:0] pick,
  output logic               valid
);

  logic [NUM_REQ-1:0] ready;
  logic [NUM_REQ-1:0] urgent;
  logic               other;

  assign ready  = ~q_empty;
  assign urgent = q_full & ready;
  assign other  = ~rr_ptr;

  // NOTE: pick gets a default before any branch so no path leaves it unassigned (no latch).
  always_comb begin
    pick = '0;
    if ($onehot(urgent)) begin
      pick = urgent;
    end else if (ready[rr_ptr]) begin
      pick[rr_ptr] = 1'b1;
    end else if (ready[other]) begin
      pick[other] = 1'b1;
    end
  end

  assign valid = |pick;

endmodule

// File: rtl/tx_scheduler.sv
// Shares one Transmitter between two FIFOs: select, pop, capture, start, then track tx_busy.
module tx_scheduler
  import tx_scheduler_pkg::*;
#(
  parameter int WORD_SIZE   = 4,
  parameter int ACK_TIMEOUT = 15,
  parameter int COUNT_WIDTH = 8
) (
  input  logic           clock,
  input  logic           reset,
  tx_scheduler_if.master bus
);

  localparam int               ACK_W    = $clog2(ACK_TIMEOUT + 1);
  localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TIMEOUT - 1);

  state_t                 state_q, state_d;
  logic [NUM_REQ-1:0]     grant_q, grant_d;
  logic [WORD_SIZE-1:0]   tx_data_q, tx_data_d;
  logic [ACK_W-1:0]       ack_q, ack_d;
  logic                   error_q, error_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   rr_q, rr_d;
  logic [NUM_REQ-1:0]     pick;
  logic                   pick_valid;
  logic [WORD_SIZE-1:0]   word_sel;

  tx_scheduler_rr_arbiter u_arbiter (
    .q_empty (bus.q_empty),
    .q_full  (bus.q_full),
    .rr_ptr  (rr_q),
    .pick    (pick),
    .valid   (pick_valid)
  );

  assign word_sel = grant_q[1] ? bus.q_data[WORD_SIZE +: WORD_SIZE]
                               : bus.q_data[0 +: WORD_SIZE];

  // NOTE: state registers use non-blocking assignment so every flop updates from pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      tx_data_q <= '0;
      ack_q     <= '0;
      error_q   <= 1'b0;
      count_q   <= '0;
      rr_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      tx_data_q <= tx_data_d;
      ack_q     <= ack_d;
      error_q   <= error_d;
      count_q   <= count_d;
      rr_q      <= rr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    tx_data_d = tx_data_q;
    ack_d     = ack_q;
    error_d   = error_q;
    count_d   = count_q;
    rr_d      = rr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!bus.tx_busy && pick_valid) begin
          grant_d = pick;
          state_d = ST_READ;
        end
      end
      ST_READ:    state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        tx_data_d = word_sel;
        state_d   = ST_START;
      end
      ST_START: begin
        ack_d   = '0;
        state_d = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        // Busy wins over the timeout even on the last allowed cycle.
        if (bus.tx_busy) begin
          state_d = ST_WAIT_DONE;
        end else if (ack_q == ACK_LAST) begin
          error_d = 1'b1;
          rr_d    = grant_q[0];
          grant_d = '0;
          state_d = ST_IDLE;
        end else begin
          ack_d = ack_q + 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (!bus.tx_busy) begin
          count_d = count_q + 1'b1;
          rr_d    = grant_q[0];
          grant_d = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.q_read     = (state_q == ST_READ) ? grant_q : '0;
  assign bus.tx_start   = (state_q == ST_START);
  assign bus.tx_data    = tx_data_q;
  assign bus.grant      = grant_q;
  assign bus.error      = error_q;
  assign bus.sent_count = count_q;

endmodule

// File: tb/tb_tx_scheduler.sv
// Randomized bench for tx_scheduler: FIFO and Transmitter models plus a transaction-level predictor.
module tb_tx_scheduler;
  import tx_scheduler_pkg::*;

  localparam int WORD_SIZE   = 4;
  localparam int ACK_TIMEOUT = 15;
  localparam int COUNT_WIDTH = 8;
  localparam int DEPTH       = 4;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  tx_scheduler_if #(.WORD_SIZE(WORD_SIZE), .COUNT_WIDTH(COUNT_WIDTH)) bus ();

  tx_scheduler #(
    .WORD_SIZE   (WORD_SIZE),
    .ACK_TIMEOUT (ACK_TIMEOUT),
    .COUNT_WIDTH (COUNT_WIDTH)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // FIFO models with registered data_out
  logic [WORD_SIZE-1:0] fq0[$];
  logic [WORD_SIZE-1:0] fq1[$];
  logic [WORD_SIZE-1:0] dout0 = '0;
  logic [WORD_SIZE-1:0] dout1 = '0;

  function automatic int fsize(input int i);
    return (i == 0) ? fq0.size() : fq1.size();
  endfunction

  function automatic logic [WORD_SIZE-1:0] ffront(input int i);
    if (fsize(i) == 0) return '0;
    return (i == 0) ? fq0[0] : fq1[0];
  endfunction

  task automatic fpush(input int i, input logic [WORD_SIZE-1:0] w);
    if (i == 0) fq0.push_back(w);
    else        fq1.push_back(w);
  endtask

  // Knobs and Transmitter model
  bit force_busy = 0;
  bit model_busy = 0;
  bit rand_push  = 0;
  bit rand_tx    = 0;
  bit never_mode = 0;
  int d_rise = 2;
  int d_len  = 5;
  int rise_cnt = 0, len_cnt = 0, cur_len = 0, done_chk = 0, to_cnt = 0;

  // Reference model of the scheduler at transaction level
  bit in_flight = 0;
  int sel = 0, rr = 0, cnt = 0, cyc = 0, rd_cyc = 0, n_reads = 0;
  bit err = 0;
  logic [WORD_SIZE-1:0] exp_word = '0;
  logic [WORD_SIZE-1:0] last_start_data = '0;
  logic [1:0] sel_log[$];

  // Inputs as the DUT saw them at the last rising edge
  logic [1:0] e_empty, e_full, rd_seen = 2'b00;
  logic       e_busy, e_rst;

  function automatic logic [1:0] oh(input int i);
    return (i == 1) ? 2'b10 : 2'b01;
  endfunction

  // Lone full queue first, otherwise the preferred queue if it holds data, else the other one.
  function automatic int pick_ref(input logic [1:0] e, input logic [1:0] f, input int ptr);
    logic [1:0] ne;
    logic [1:0] fu;
    ne = ~e;
    fu = f & ne;
    if (fu == 2'b01) return 0;
    if (fu == 2'b10) return 1;
    if (ne[ptr]) return ptr;
    return 1 - ptr;
  endfunction

  task automatic refresh();
    bus.q_empty = {fq1.size() == 0, fq0.size() == 0};
    bus.q_full  = {fq1.size() >= DEPTH, fq0.size() >= DEPTH};
    bus.q_data  = {dout1, dout0};
    bus.tx_busy = force_busy | model_busy;
  endtask

  task automatic start_tx();
    bit never;
    never = never_mode;
    rise_cnt = d_rise;
    cur_len  = d_len;
    if (rand_tx) begin
      never    = ($urandom_range(7) == 0);
      rise_cnt = $urandom_range(6, 1);
      cur_len  = $urandom_range(6, 1);
    end
    if (never) begin
      rise_cnt = 0;
      to_cnt   = ACK_TIMEOUT + 1;
    end
  endtask

  task automatic observe();
    bit idle_at_edge;
    bit exp_start;
    int s;
    cyc++;
    rd_seen = bus.q_read;
    if (bus.q_read != 2'b00) n_reads++;
    if (!e_rst) begin
      check("reset_outputs", {bus.q_read, bus.tx_start, bus.tx_data, bus.grant, bus.error,
                              bus.sent_count}, '0);
      in_flight = 0; rr = 0; cnt = 0; err = 0;
      to_cnt = 0; done_chk = 0; rise_cnt = 0; len_cnt = 0; model_busy = 0;
      refresh();
      return;
    end
    idle_at_edge = !in_flight;
    if (done_chk > 0) begin
      done_chk--;
      if (done_chk == 0) begin
        cnt++; rr = 1 - sel; in_flight = 0;
      end
    end
    if (to_cnt > 0) begin
      to_cnt--;
      if (to_cnt == 0) begin
        err = 1; rr = 1 - sel; in_flight = 0;
      end
    end
    if (idle_at_edge && !e_busy && e_empty != 2'b11) begin
      s = pick_ref(e_empty, e_full, rr);
      check("q_read_pick", bus.q_read, oh(s));
      sel_log.push_back(bus.q_read);
      in_flight = 1; sel = s; exp_word = ffront(s); rd_cyc = cyc;
    end else begin
      check("q_read_quiet", bus.q_read, 2'b00);
    end
    check("grant", bus.grant, in_flight ? oh(sel) : 2'b00);
    exp_start = in_flight && (cyc == rd_cyc + 2);
    check("tx_start", bus.tx_start, exp_start);
    if (exp_start) begin
      last_start_data = bus.tx_data;
      check("tx_data", bus.tx_data, exp_word);
      start_tx();
    end
    check("error", bus.error, err);
    check("sent_count", bus.sent_count, cnt % (1 << COUNT_WIDTH));
  endtask

  task automatic cycle();
    @(posedge clock);
    e_empty = bus.q_empty;
    e_full  = bus.q_full;
    e_busy  = bus.tx_busy;
    e_rst   = reset;
    #1;
    if (rd_seen[0] && fq0.size() > 0) dout0 = fq0.pop_front();
    if (rd_seen[1] && fq1.size() > 0) dout1 = fq1.pop_front();
    if (rise_cnt > 0) begin
      rise_cnt--;
      if (rise_cnt == 0) begin
        model_busy = 1; len_cnt = cur_len;
      end
    end else if (model_busy) begin
      len_cnt--;
      if (len_cnt == 0) begin
        model_busy = 0; done_chk = 2;
      end
    end
    if (rand_push) begin
      for (int i = 0; i < NUM_REQ; i++)
        if ($urandom_range(2) == 0 && fsize(i) < DEPTH)
          fpush(i, WORD_SIZE'($urandom_range(15)));
    end
    refresh();
    @(negedge clock);
    observe();
  endtask

  task automatic drain(input int max_cyc);
    int k;
    k = 0;
    while ((in_flight || fq0.size() > 0 || fq1.size() > 0) && k < max_cyc) begin
      cycle();
      k++;
    end
    check("drain_bound", {31'd0, in_flight, fq0.size() + fq1.size()}, '0);
    cycle();
  endtask

  initial begin
    int base_cnt;
    int base_reads;
    int k;
    reset = 1'b0;
    fpush(0, 4'h3);
    fpush(1, 4'h5);
    refresh();

    // Reset held two cycles with both queues loaded, then release
    repeat (2) cycle();
    reset = 1'b1;
    cycle();
    check("release_q_read", bus.q_read, 2'b01);
    drain(200);

    // Single word from requester 0
    base_cnt = cnt; base_reads = n_reads;
    fpush(0, 4'hA);
    refresh();
    drain(100);
    check("single_pops", n_reads - base_reads, 1);
    check("single_tx_data", last_start_data, 4'hA);
    check("single_sent", bus.sent_count, base_cnt + 1);
    check("single_grant_idle", bus.grant, 2'b00);

    // Round-robin from a fresh reset
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    sel_log.delete();
    for (int i = 0; i < 2; i++) begin
      fpush(0, WORD_SIZE'(4'h1 + i));
      fpush(1, WORD_SIZE'(4'h8 + i));
    end
    refresh();
    drain(200);
    check("rr_count", sel_log.size(), 4);
    for (int i = 0; i < 4 && i < sel_log.size(); i++)
      check("rr_seq", sel_log[i], (i % 2 == 1) ? 2'b10 : 2'b01);
    check("rr_sent", bus.sent_count, 4);

    // Full queue 1 overrides rr_ptr=0; afterwards requester 0 follows
    sel_log.delete();
    for (int i = 0; i < DEPTH; i++) fpush(1, WORD_SIZE'(4'hC + i));
    fpush(0, 4'h2);
    refresh();
    drain(300);
    check("full_first", sel_log.size() > 0 ? sel_log[0] : 2'b00, 2'b10);
    check("full_second", sel_log.size() > 1 ? sel_log[1] : 2'b00, 2'b01);

    // Handshake timeout, then a normal transfer with error sticky
    base_cnt = cnt;
    never_mode = 1;
    fpush(0, 4'h7);
    refresh();
    drain(100);
    check("to_error", bus.error, 1'b1);
    check("to_sent", bus.sent_count, base_cnt % (1 << COUNT_WIDTH));
    check("to_grant", bus.grant, 2'b00);
    never_mode = 0;
    fpush(1, 4'h9);
    refresh();
    drain(100);
    check("after_to_sent", bus.sent_count, (base_cnt + 1) % (1 << COUNT_WIDTH));
    check("error_sticky", bus.error, 1'b1);

    // Reset while the Transmitter is busy
    d_len = 10;
    fpush(0, 4'hC);
    refresh();
    k = 0;
    while (!model_busy && k < 30) begin
      cycle();
      k++;
    end
    check("midrst_busy_seen", model_busy, 1'b1);
    repeat (2) cycle();
    reset = 1'b0;
    cycle();
    check("midrst_outputs", {bus.q_read, bus.tx_start, bus.tx_data, bus.grant, bus.error,
                             bus.sent_count}, '0);
    reset = 1'b1;
    d_len = 5;
    cycle();

    // Busy already high in IDLE blocks any pop
    force_busy = 1;
    base_reads = n_reads;
    fpush(0, 4'h6);
    fpush(1, 4'hE);
    refresh();
    repeat (6) cycle();
    check("gate_no_read", n_reads - base_reads, 0);
    force_busy = 0;
    refresh();
    drain(200);
    check("gate_reads", n_reads - base_reads, 2);

    // Random traffic from a clean reset
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    rand_push = 1;
    rand_tx   = 1;
    repeat (2000) cycle();
    rand_push = 0;
    drain(400);
    rand_tx = 0;
    repeat (3) cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
